// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for a MIPS-subset datapath.
// It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath select and write enable. A shared instruction/data memory is
// handshaked through mem_ready.
// Outputs are decoded from the current state, the instruction class latched in
// DECODE, and the live mem_ready/zero/run inputs. Several of them must react
// in the same cycle as those inputs (the fetch commit, the beq PC write and the
// fetch request right after reset), so they cannot be registered.
// While rst_n is low every output is forced to 0.
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic       sign_ext,
    output logic       halted,
    output logic       retire,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_SLT, I_JR, I_ADDI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_t r_state;
    instr_t r_instr;
    logic   r_fetch_pend;   // fetch request issued and still waiting for mem_ready
    instr_t w_instr;
    logic   w_fetch_go;
    logic [2:0] w_alu_op;
    logic       w_alu_src_b;
    logic       w_sign_ext;

    // Once a fetch request is out, it is held until mem_ready even if run drops.
    assign w_fetch_go = run | r_fetch_pend;
    assign state      = r_state;

    // Classify the instruction register. funct only matters for opcode 0.
    always_comb begin
        w_instr = I_ILL;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20:   w_instr = I_ADD;
                6'h22:   w_instr = I_SUB;
                6'h2A:   w_instr = I_SLT;
                6'h08:   w_instr = I_JR;
                default: w_instr = I_ILL;
            endcase
        end else begin
            case (opcode)
                6'h08:   w_instr = I_ADDI;
                6'h23:   w_instr = I_LW;
                6'h2B:   w_instr = I_SW;
                6'h04:   w_instr = I_BEQ;
                6'h02:   w_instr = I_J;
                6'h03:   w_instr = I_JAL;
                default: w_instr = I_ILL;
            endcase
        end
    end

    // ALU setup chosen in EXEC and held through MEM/WB so the result stays stable.
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_src_b = 1'b0;
        w_sign_ext  = 1'b0;
        case (r_instr)
            I_SUB: w_alu_op = ALU_SUB;
            I_SLT: w_alu_op = ALU_SLT;
            I_ADDI, I_LW, I_SW: begin
                w_alu_src_b = 1'b1;
                w_sign_ext  = 1'b1;
            end
            I_BEQ: begin
                w_alu_op   = ALU_SUB;
                w_sign_ext = 1'b1;
            end
            default: ;
        endcase
    end

    // State sequencing; the instruction class is captured once in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_instr      <= I_ILL;
            r_fetch_pend <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_go) begin
                        if (mem_ready) begin
                            r_state      <= S_DECODE;
                            r_fetch_pend <= 1'b0;
                        end else begin
                            r_fetch_pend <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    r_instr <= w_instr;
                    if (w_instr == I_ILL && HALT_ON_ILLEGAL)
                        r_state <= S_HALT;
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_instr)
                        I_ADD, I_SUB, I_SLT, I_ADDI: r_state <= S_WB;
                        I_LW, I_SW:                  r_state <= S_MEM;
                        default:                     r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        r_state <= (r_instr == I_LW) ? S_WB : S_FETCH;
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath controls for the current cycle; everything is 0 while in reset.
    always_comb begin
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        pc_src    = 2'b00;
        iord      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        reg_dst   = 2'b00;
        wb_sel    = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        sign_ext  = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_go) begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            ir_wr = 1'b1;
                            pc_wr = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    alu_op    = w_alu_op;
                    alu_src_b = w_alu_src_b;
                    sign_ext  = w_sign_ext;
                    case (r_instr)
                        I_BEQ: begin
                            pc_wr  = zero;
                            pc_src = 2'b01;
                            retire = 1'b1;
                        end
                        I_J: begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b10;
                            retire = 1'b1;
                        end
                        I_JAL: begin
                            pc_wr   = 1'b1;
                            pc_src  = 2'b10;
                            reg_wr  = 1'b1;
                            reg_dst = 2'b10;
                            wb_sel  = 2'b10;
                            retire  = 1'b1;
                        end
                        I_JR: begin
                            pc_wr  = 1'b1;
                            pc_src = 2'b11;
                            retire = 1'b1;
                        end
                        I_ILL:   retire = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_op    = w_alu_op;
                    alu_src_b = w_alu_src_b;
                    sign_ext  = w_sign_ext;
                    iord      = 1'b1;
                    mem_rd    = (r_instr == I_LW);
                    mem_wr    = (r_instr == I_SW);
                    retire    = mem_ready && (r_instr == I_SW);
                end
                S_WB: begin
                    alu_op    = w_alu_op;
                    alu_src_b = w_alu_src_b;
                    sign_ext  = w_sign_ext;
                    reg_wr    = 1'b1;
                    retire    = 1'b1;
                    if (r_instr == I_ADD || r_instr == I_SUB || r_instr == I_SLT)
                        reg_dst = 2'b01;
                    if (r_instr == I_LW)
                        wb_sel = 2'b01;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Two instances share all inputs: one halts on
// illegal instructions, the other retires them as no-ops. Expected controls are
// built per instruction from a table of instruction attributes and the phase
// sequence (fetch waits, decode, exec, memory waits, write-back).
module tb_multicycle_control;

    localparam int C_ADD = 0, C_SUB = 1, C_SLT = 2, C_JR = 3, C_ADDI = 4;
    localparam int C_LW = 5, C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_ILL = 10;
    localparam int PH_FWAIT = 0, PH_FDONE = 1, PH_DEC = 2, PH_EXEC = 3;
    localparam int PH_MWAIT = 4, PH_MDONE = 5, PH_WB = 6, PH_HALT = 7;

    typedef struct packed {
        logic       halted;
        logic       retire;
        logic [2:0] st;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       sign_ext;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] aop;
        logic       imm;
        logic       se;
        logic       mem;
        logic       store;
        logic       wb;
        logic [1:0] rdst;
        logic [1:0] wsel;
        logic       jump;
        logic [1:0] psrc;
        logic       link;
        logic       beq;
    } info_t;

    logic       clk = 1'b0;
    logic       rst_n, run, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic [5:0] cur_op, cur_fn;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       a_ir_wr, a_pc_wr, a_iord, a_mem_rd, a_mem_wr, a_reg_wr, a_alu_src_b, a_sign_ext, a_halted, a_retire;
    logic [1:0] a_pc_src, a_reg_dst, a_wb_sel;
    logic [2:0] a_alu_op, a_state;
    logic       b_ir_wr, b_pc_wr, b_iord, b_mem_rd, b_mem_wr, b_reg_wr, b_alu_src_b, b_sign_ext, b_halted, b_retire;
    logic [1:0] b_pc_src, b_reg_dst, b_wb_sel;
    logic [2:0] b_alu_op, b_state;
    ctl_t       obs_a, obs_b;

    always #5 clk = ~clk;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .ir_wr(a_ir_wr), .pc_wr(a_pc_wr), .pc_src(a_pc_src), .iord(a_iord),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .reg_wr(a_reg_wr), .reg_dst(a_reg_dst),
        .wb_sel(a_wb_sel), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .sign_ext(a_sign_ext),
        .halted(a_halted), .retire(a_retire), .state(a_state)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .ir_wr(b_ir_wr), .pc_wr(b_pc_wr), .pc_src(b_pc_src), .iord(b_iord),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .reg_wr(b_reg_wr), .reg_dst(b_reg_dst),
        .wb_sel(b_wb_sel), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .sign_ext(b_sign_ext),
        .halted(b_halted), .retire(b_retire), .state(b_state)
    );

    assign obs_a = {a_halted, a_retire, a_state, a_ir_wr, a_pc_wr, a_pc_src, a_iord, a_mem_rd,
                    a_mem_wr, a_reg_wr, a_reg_dst, a_wb_sel, a_alu_src_b, a_alu_op, a_sign_ext};
    assign obs_b = {b_halted, b_retire, b_state, b_ir_wr, b_pc_wr, b_pc_src, b_iord, b_mem_rd,
                    b_mem_wr, b_reg_wr, b_reg_dst, b_wb_sel, b_alu_src_b, b_alu_op, b_sign_ext};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction attributes straight from the instruction list.
    function automatic info_t info(input int cls);
        info_t n;
        n = '0;
        case (cls)
            C_ADD:  begin n.fn = 6'h20; n.wb = 1'b1; n.rdst = 2'b01; end
            C_SUB:  begin n.fn = 6'h22; n.aop = 3'b001; n.wb = 1'b1; n.rdst = 2'b01; end
            C_SLT:  begin n.fn = 6'h2A; n.aop = 3'b011; n.wb = 1'b1; n.rdst = 2'b01; end
            C_JR:   begin n.fn = 6'h08; n.jump = 1'b1; n.psrc = 2'b11; end
            C_ADDI: begin n.op = 6'h08; n.imm = 1'b1; n.se = 1'b1; n.wb = 1'b1; end
            C_LW:   begin n.op = 6'h23; n.imm = 1'b1; n.se = 1'b1; n.mem = 1'b1; n.wb = 1'b1; n.wsel = 2'b01; end
            C_SW:   begin n.op = 6'h2B; n.imm = 1'b1; n.se = 1'b1; n.mem = 1'b1; n.store = 1'b1; end
            C_BEQ:  begin n.op = 6'h04; n.aop = 3'b001; n.se = 1'b1; n.beq = 1'b1; end
            C_J:    begin n.op = 6'h02; n.jump = 1'b1; n.psrc = 2'b10; end
            C_JAL:  begin n.op = 6'h03; n.jump = 1'b1; n.psrc = 2'b10; n.link = 1'b1; end
            default: n.op = 6'h3F;
        endcase
        return n;
    endfunction

    // Expected control word for one phase of one instruction.
    function automatic ctl_t exp_ctl(input int cls, input int ph, input logic zv);
        ctl_t  e;
        info_t n;
        e = '0;
        n = info(cls);
        if (ph == PH_EXEC || ph == PH_MWAIT || ph == PH_MDONE || ph == PH_WB) begin
            e.alu_op    = n.aop;
            e.alu_src_b = n.imm;
            e.sign_ext  = n.se;
        end
        case (ph)
            PH_FWAIT: e.mem_rd = 1'b1;
            PH_FDONE: begin e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
            PH_DEC:   e.st = 3'd1;
            PH_EXEC: begin
                e.st = 3'd2;
                if (n.beq) begin e.pc_wr = zv; e.pc_src = 2'b01; e.retire = 1'b1; end
                if (n.jump) begin e.pc_wr = 1'b1; e.pc_src = n.psrc; e.retire = 1'b1; end
                if (n.link) begin e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wb_sel = 2'b10; end
                if (cls == C_ILL) e.retire = 1'b1;
            end
            PH_MWAIT, PH_MDONE: begin
                e.st     = 3'd3;
                e.iord   = 1'b1;
                e.mem_rd = ~n.store;
                e.mem_wr = n.store;
                e.retire = (ph == PH_MDONE) && n.store;
            end
            PH_WB: begin
                e.st = 3'd4; e.reg_wr = 1'b1; e.retire = 1'b1;
                e.reg_dst = n.rdst; e.wb_sel = n.wsel;
            end
            PH_HALT: begin e.st = 3'd7; e.halted = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check 1 time unit later.
    task automatic step(input logic run_v, input logic rdy_v, input logic zv,
                        input ctl_t ea, input ctl_t eb, input bit chk_b, input string tag);
        @(negedge clk);
        run = run_v; mem_ready = rdy_v; zero = zv; opcode = cur_op; funct = cur_fn;
        #1;
        check_val({tag, "/A"}, 32'(obs_a), 32'(ea));
        if (chk_b) check_val({tag, "/B"}, 32'(obs_b), 32'(eb));
    endtask

    task automatic step2(input logic run_v, input logic rdy_v, input logic zv, input ctl_t e, input string tag);
        step(run_v, rdy_v, zv, e, e, 1'b1, tag);
    endtask

    // Reset with run and mem_ready high: all outputs must stay 0 throughout.
    task automatic reset_duts();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        #1;
        check_val("reset/A", 32'(obs_a), 32'd0);
        check_val("reset/B", 32'(obs_b), 32'd0);
        @(posedge clk);
        #1;
        check_val("reset.edge/A", 32'(obs_a), 32'd0);
        run = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            step2(1'b0, 1'($urandom), 1'($urandom), '0, "idle");
    endtask

    // One full instruction with fw fetch wait cycles and mw memory wait cycles.
    task automatic do_instr(input int cls, input int fw, input int mw, input logic zv);
        info_t n;
        string nm;
        logic [5:0] fn;
        n  = info(cls);
        nm = $sformatf("c%0d", cls);
        fn = (n.op == 6'h00) ? n.fn : 6'($urandom);
        for (int i = 0; i < fw; i++)
            step2(1'b1, 1'b0, 1'($urandom), exp_ctl(cls, PH_FWAIT, 1'b0), {nm, ".fwait"});
        step2(1'b1, 1'b1, 1'($urandom), exp_ctl(cls, PH_FDONE, 1'b0), {nm, ".fdone"});
        cur_op = n.op;
        cur_fn = fn;
        step2(1'($urandom), 1'($urandom), 1'($urandom), exp_ctl(cls, PH_DEC, 1'b0), {nm, ".dec"});
        step2(1'($urandom), 1'($urandom), zv, exp_ctl(cls, PH_EXEC, zv), {nm, ".exec"});
        if (n.mem) begin
            for (int i = 0; i < mw; i++)
                step2(1'($urandom), 1'b0, 1'($urandom), exp_ctl(cls, PH_MWAIT, 1'b0), {nm, ".mwait"});
            step2(1'($urandom), 1'b1, 1'($urandom), exp_ctl(cls, PH_MDONE, 1'b0), {nm, ".mdone"});
        end
        if (n.wb)
            step2(1'($urandom), 1'($urandom), 1'($urandom), exp_ctl(cls, PH_WB, 1'b0), {nm, ".wb"});
    endtask

    // Illegal encoding: instance A halts for good, instance B retires and refetches.
    task automatic do_illegal(input logic [5:0] op, input logic [5:0] fn);
        ctl_t h;
        h = exp_ctl(C_ILL, PH_HALT, 1'b0);
        reset_duts();
        step2(1'b1, 1'b1, 1'b0, exp_ctl(C_ILL, PH_FDONE, 1'b0), "ill.fdone");
        cur_op = op;
        cur_fn = fn;
        step2(1'b1, 1'b0, 1'b0, exp_ctl(C_ILL, PH_DEC, 1'b0), "ill.dec");
        step(1'b1, 1'b0, 1'b0, h, exp_ctl(C_ILL, PH_EXEC, 1'b0), 1'b1, "ill.exec");
        check_val("ill.halted", 32'(a_halted), 32'd1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, h, exp_ctl(C_ILL, PH_FWAIT, 1'b0), 1'b1, "ill.after");
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, 1'($urandom), h, '0, 1'b0, "ill.stay");
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'h00; funct = 6'h00; cur_op = 6'h00; cur_fn = 6'h00;
        reset_duts();

        // Directed sequence from the instruction set.
        do_instr(C_ADDI, 0, 0, 1'b0);
        do_instr(C_ADD, 0, 0, 1'b0);
        do_instr(C_SUB, 0, 0, 1'b1);
        do_instr(C_SLT, 0, 0, 1'b0);
        do_instr(C_LW, 2, 3, 1'b0);
        do_instr(C_BEQ, 0, 0, 1'b1);
        do_instr(C_BEQ, 0, 0, 1'b0);
        do_instr(C_JAL, 0, 0, 1'b0);
        do_instr(C_JR, 0, 0, 1'b0);
        do_instr(C_J, 1, 0, 1'b1);
        do_instr(C_SW, 0, 2, 1'b0);
        idle(4);
        do_instr(C_LW, 0, 0, 1'b0);

        // Reset asserted while a store waits in MEM.
        reset_duts();
        cur_fn = 6'h11;
        step2(1'b1, 1'b1, 1'b0, exp_ctl(C_SW, PH_FDONE, 1'b0), "rsw.fdone");
        cur_op = 6'h2B;
        step2(1'b1, 1'b0, 1'b0, exp_ctl(C_SW, PH_DEC, 1'b0), "rsw.dec");
        step2(1'b1, 1'b0, 1'b0, exp_ctl(C_SW, PH_EXEC, 1'b0), "rsw.exec");
        step2(1'b1, 1'b0, 1'b0, exp_ctl(C_SW, PH_MWAIT, 1'b0), "rsw.mwait");
        #1 rst_n = 1'b0;
        #1;
        check_val("rsw.mem_wr", 32'(a_mem_wr), 32'd0);
        check_val("rsw.state", 32'(a_state), 32'd0);
        check_val("rsw.all/B", 32'(obs_b), 32'd0);
        @(posedge clk);
        #1;
        run = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        step2(1'b1, 1'b0, 1'b0, exp_ctl(C_SW, PH_FWAIT, 1'b0), "rsw.refetch");

        do_illegal(6'h3F, 6'($urandom));
        do_illegal(6'h00, 6'h3F);

        // Random instruction stream with random waits, idle gaps and input noise.
        reset_duts();
        for (int k = 0; k < 150; k++) begin
            idle(int'($urandom_range(0, 2)));
            do_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
